// File: rtl/mixcol_engine.sv
// AES MixColumns / InvMixColumns engine: one block at a time, COLS_PER_CYCLE
// columns transformed per clock by an array of per-column lanes.

module mixcol_column (
    input  logic        inv,
    input  logic [31:0] col_in,
    output logic [31:0] col_out
);
    logic [0:3][7:0] a, b;

    function automatic logic [7:0] xt(input logic [7:0] v);
        return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
    endfunction

    // k is always a constant at the call site, so this folds to an XOR tree
    function automatic logic [7:0] gmul(input logic [7:0] v, input logic [3:0] k);
        logic [7:0] x2, x4, x8;
        x2 = xt(v);
        x4 = xt(x2);
        x8 = xt(x4);
        return ({8{k[0]}} & v) ^ ({8{k[1]}} & x2) ^ ({8{k[2]}} & x4) ^ ({8{k[3]}} & x8);
    endfunction

    assign a       = col_in;
    assign col_out = b;

    for (genvar r = 0; r < 4; r++) begin : g_row
        assign b[r] = inv ?
            gmul(a[r], 4'he) ^ gmul(a[(r+1)%4], 4'hb) ^ gmul(a[(r+2)%4], 4'hd) ^ gmul(a[(r+3)%4], 4'h9) :
            gmul(a[r], 4'h2) ^ gmul(a[(r+1)%4], 4'h3) ^ a[(r+2)%4] ^ a[(r+3)%4];
    end
endmodule

module mixcol_engine #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_mode,
    input  logic [0:127] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [0:127] out_data,
    output logic         busy
);
    localparam int         NG       = 4 / COLS_PER_CYCLE;
    localparam logic [1:0] LAST_GRP = 2'(NG - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cfg
        $error("mixcol_engine: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    logic [1:0]   state;
    logic [1:0]   grp;
    logic         mode;
    logic [0:127] work;

    logic [COLS_PER_CYCLE-1:0][1:0]  lane_col;
    logic [COLS_PER_CYCLE-1:0][31:0] lane_in, lane_out;

    for (genvar l = 0; l < COLS_PER_CYCLE; l++) begin : g_lane
        assign lane_col[l] = 2'(grp * COLS_PER_CYCLE) + 2'(l);
        assign lane_in[l]  = work[{lane_col[l], 5'd0} +: 32];
        mixcol_column u_col (
            .inv    (mode),
            .col_in (lane_in[l]),
            .col_out(lane_out[l])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            grp   <= 2'd0;
            mode  <= 1'b0;
            work  <= '0;
        end else begin
            case (state)
                S_IDLE: if (in_valid) begin
                    work  <= in_data;
                    mode  <= in_mode;
                    grp   <= 2'd0;
                    state <= S_BUSY;
                end
                S_BUSY: begin
                    for (int l = 0; l < COLS_PER_CYCLE; l++)
                        work[{lane_col[l], 5'd0} +: 32] <= lane_out[l];
                    if (grp == LAST_GRP) begin
                        grp   <= 2'd0;
                        state <= S_DONE;
                    end else begin
                        grp <= grp + 2'd1;
                    end
                end
                S_DONE: if (out_ready) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state == S_IDLE);
    assign busy      = (state == S_BUSY);
    assign out_valid = (state == S_DONE);
    assign out_data  = work;
endmodule

// File: tb/tb_mixcol_engine.sv
// Directed bench for mixcol_engine: one instance per legal COLS_PER_CYCLE,
// hand-computed AES column vectors, random round trips, protocol corner cases.

module tb_mixcol_engine;
    localparam int ND = 3;

    localparam logic [0:127] V_FWD_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [0:127] V_FWD_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [0:127] V_INV_IN  = 128'h8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8;
    localparam logic [0:127] V_INV_OUT = 128'hdb135345_f20a225c_d4d4d4d5_2d26314c;

    localparam logic [31:0] P_IN  [6] = '{32'hdb135345, 32'hf20a225c, 32'h01010101,
                                          32'hc6c6c6c6, 32'hd4d4d4d5, 32'h2d26314c};
    localparam logic [31:0] P_OUT [6] = '{32'h8e4da1bc, 32'h9fdc589d, 32'h01010101,
                                          32'hc6c6c6c6, 32'hd5d5d7d6, 32'h4d7ebdf8};

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [ND-1:0] in_valid_v, in_mode_v, out_ready_v, in_ready_v, out_valid_v, busy_v;
    logic [0:127]  in_data_v  [ND];
    logic [0:127]  out_data_v [ND];

    int n_vec = 0;
    int n_err = 0;

    for (genvar i = 0; i < ND; i++) begin : g_dut
        mixcol_engine #(.COLS_PER_CYCLE(1 << i)) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_valid (in_valid_v[i]),
            .in_ready (in_ready_v[i]),
            .in_mode  (in_mode_v[i]),
            .in_data  (in_data_v[i]),
            .out_valid(out_valid_v[i]),
            .out_ready(out_ready_v[i]),
            .out_data (out_data_v[i]),
            .busy     (busy_v[i])
        );
    end

    function automatic int ngrp(int i);
        return 4 >> i;
    endfunction

    function automatic logic [0:127] b2b_in(int k);
        return {P_IN[k%6], P_IN[(k+1)%6], P_IN[(k+2)%6], P_IN[(k/6)%6]};
    endfunction

    function automatic logic [0:127] b2b_out(int k);
        return {P_OUT[k%6], P_OUT[(k+1)%6], P_OUT[(k+2)%6], P_OUT[(k/6)%6]};
    endfunction

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic m, input logic [0:127] d, input logic r);
        for (int i = 0; i < ND; i++) begin
            in_valid_v[i]  = v;
            in_mode_v[i]   = m;
            in_data_v[i]   = d;
            out_ready_v[i] = r;
        end
    endtask

    // Capture one block in every instance, check latency and (optionally) data.
    task automatic run_block(input string tag, input logic [0:127] d, input logic m,
                             input logic do_chk, input logic [0:127] exp,
                             output logic [0:127] res);
        logic [ND-1:0] seen;
        seen = '0;
        res  = '0;
        drive(1'b1, m, d, 1'b1);
        tick();
        drive(1'b0, 1'b0, '0, 1'b1);
        for (int k = 1; k <= 8; k++) begin
            tick();
            for (int i = 0; i < ND; i++) begin
                if (out_valid_v[i] && !seen[i]) begin
                    seen[i] = 1'b1;
                    chk($sformatf("%s lat c%0d", tag, 1 << i), 128'(k), 128'(ngrp(i)));
                    if (do_chk)
                        chk($sformatf("%s data c%0d", tag, 1 << i), out_data_v[i], exp);
                    if (i == 0) res = out_data_v[0];
                end
            end
        end
        for (int i = 0; i < ND; i++)
            chk($sformatf("%s done c%0d", tag, 1 << i), 128'(seen[i]), 128'(1));
    endtask

    initial begin
        logic [0:127] res, blk;
        int sent [ND];
        int recv [ND];
        int last_t [ND];
        int cyc;

        rst_n = 1'b0;
        drive(1'b0, 1'b0, '0, 1'b0);
        tick();
        tick();
        for (int i = 0; i < ND; i++) begin
            chk($sformatf("rst in_ready c%0d", 1 << i), 128'(in_ready_v[i]), 128'(1));
            chk($sformatf("rst out_valid c%0d", 1 << i), 128'(out_valid_v[i]), 128'(0));
            chk($sformatf("rst busy c%0d", 1 << i), 128'(busy_v[i]), 128'(0));
            chk($sformatf("rst data c%0d", 1 << i), out_data_v[i], '0);
        end
        rst_n = 1'b1;

        run_block("fwd", V_FWD_IN, 1'b0, 1'b1, V_FWD_OUT, res);
        run_block("inv", V_INV_IN, 1'b1, 1'b1, V_INV_OUT, res);

        for (int n = 0; n < 1000; n++) begin
            blk = {$urandom, $urandom, $urandom, $urandom};
            run_block("rt fwd", blk, 1'b0, 1'b0, '0, res);
            run_block("rt inv", res, 1'b1, 1'b1, blk, res);
        end

        // backpressure: result must sit untouched in DONE
        drive(1'b1, 1'b0, V_FWD_IN, 1'b0);
        tick();
        drive(1'b0, 1'b0, '0, 1'b0);
        repeat (4) tick();
        for (int k = 0; k < 10; k++) begin
            for (int i = 0; i < ND; i++) begin
                chk($sformatf("bp valid c%0d", 1 << i), 128'(out_valid_v[i]), 128'(1));
                chk($sformatf("bp data c%0d", 1 << i), out_data_v[i], V_FWD_OUT);
                chk($sformatf("bp in_ready c%0d", 1 << i), 128'(in_ready_v[i]), 128'(0));
            end
            tick();
        end
        drive(1'b0, 1'b0, '0, 1'b1);
        tick();
        for (int i = 0; i < ND; i++) begin
            chk($sformatf("bp release rdy c%0d", 1 << i), 128'(in_ready_v[i]), 128'(1));
            chk($sformatf("bp release vld c%0d", 1 << i), 128'(out_valid_v[i]), 128'(0));
        end

        // input protection: inputs churn while the block is in flight
        drive(1'b1, 1'b0, V_FWD_IN, 1'b0);
        tick();
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, ~k[0], {$urandom, $urandom, $urandom, $urandom}, 1'b0);
            tick();
        end
        for (int i = 0; i < ND; i++) begin
            chk($sformatf("prot valid c%0d", 1 << i), 128'(out_valid_v[i]), 128'(1));
            chk($sformatf("prot data c%0d", 1 << i), out_data_v[i], V_FWD_OUT);
        end
        drive(1'b0, 1'b0, '0, 1'b1);
        tick();

        // reset mid-operation, with in_valid already high as rst_n releases
        drive(1'b1, 1'b0, V_FWD_IN, 1'b1);
        tick();
        drive(1'b0, 1'b0, '0, 1'b1);
        tick();
        chk("mid busy c1", 128'(busy_v[0]), 128'(1));
        chk("mid vld c1", 128'(out_valid_v[0]), 128'(0));
        chk("mid vld c2", 128'(out_valid_v[1]), 128'(0));
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < ND; i++) begin
            chk($sformatf("mid rst rdy c%0d", 1 << i), 128'(in_ready_v[i]), 128'(1));
            chk($sformatf("mid rst vld c%0d", 1 << i), 128'(out_valid_v[i]), 128'(0));
            chk($sformatf("mid rst data c%0d", 1 << i), out_data_v[i], '0);
        end
        run_block("post rst", V_INV_IN, 1'b1, 1'b1, V_INV_OUT, res);

        // back-to-back: 20 blocks per instance, order and spacing checked
        for (int i = 0; i < ND; i++) begin
            sent[i] = 0;
            recv[i] = 0;
            last_t[i] = 0;
        end
        drive(1'b1, 1'b0, '0, 1'b1);
        cyc = 0;
        while (cyc < 200 && !(recv[0] >= 20 && recv[1] >= 20 && recv[2] >= 20)) begin
            for (int i = 0; i < ND; i++) begin
                if (out_valid_v[i]) begin
                    chk($sformatf("b2b data c%0d #%0d", 1 << i, recv[i]), out_data_v[i], b2b_out(recv[i]));
                    if (recv[i] > 0)
                        chk($sformatf("b2b gap c%0d", 1 << i), 128'(cyc - last_t[i]), 128'(ngrp(i) + 2));
                    last_t[i] = cyc;
                    recv[i]++;
                end
                if (in_ready_v[i]) begin
                    if (sent[i] < 20) begin
                        in_data_v[i] = b2b_in(sent[i]);
                        sent[i]++;
                    end else begin
                        in_valid_v[i] = 1'b0;
                    end
                end
            end
            tick();
            cyc++;
        end
        for (int i = 0; i < ND; i++)
            chk($sformatf("b2b count c%0d", 1 << i), 128'(recv[i]), 128'(20));
        drive(1'b0, 1'b0, '0, 1'b1);
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/mixcol_engine.md
MIXCOL_ENGINE -- requirements
Module: mixcol_engine

Interface
REQ-001 SHALL have parameter COLS_PER_CYCLE, default 1, giving the columns transformed per clock; legal values are 1, 2 and 4.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-004 SHALL have port in_valid, input, 1 bit: in_data and in_mode are valid.
REQ-005 SHALL have port in_ready, output, 1 bit: the engine accepts a block.
REQ-006 SHALL have port in_mode, input, 1 bit: 0 selects forward MixColumns; 1 selects InvMixColumns.
REQ-007 SHALL have port in_data, input, [0:127]: the AES state.
  - Column c occupies bits [32c : 32c+31].
  - Row r byte of that column occupies bits [32c+8r : 32c+8r+7]; bit 0 is the MSB.
REQ-008 SHALL have port out_valid, output, 1 bit: out_data holds a completed result.
REQ-009 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-010 SHALL have port out_data, output, [0:127]: the transformed state, with the same layout as in_data.
REQ-011 SHALL have port busy, output, 1 bit: high in the BUSY state only.

Function
REQ-012 SHALL implement three states: IDLE, BUSY and DONE.
REQ-013 SHALL drive in_ready high in IDLE only.
REQ-014 SHALL, on in_valid && in_ready in IDLE:
  - capture in_data into the working register;
  - capture in_mode into the mode register;
  - clear the group counter;
  - enter BUSY.
REQ-015 SHALL, in BUSY, each cycle replace columns [g*COLS_PER_CYCLE, (g+1)*COLS_PER_CYCLE-1] of the working register with their transformed values, where g is the group counter, then increment g.
REQ-016 SHALL enter DONE on the cycle the last group (g = 4/COLS_PER_CYCLE-1) is written; the counter SHALL then wrap to 0.
REQ-017 SHALL assert out_valid in DONE only; out_valid rises exactly 4/COLS_PER_CYCLE cycles after the capture edge.
REQ-018 SHALL hold out_data and out_valid stable in DONE until out_valid && out_ready; on that handshake it SHALL enter IDLE.
  - Sustained throughput is one block per 4/COLS_PER_CYCLE+2 cycles.
REQ-019 SHALL drive out_data from the working register; its value outside DONE is don't-care for the consumer but SHALL be deterministic.
REQ-020 SHALL ignore in_valid and in_mode outside IDLE; a mode change after capture SHALL NOT affect the block in flight.
REQ-021 SHALL ignore out_ready outside DONE.
REQ-022 SHALL compute the forward transform as rows {02 03 01 01} circulant over GF(2^8), with reduction polynomial 0x11B.
REQ-023 SHALL compute the inverse transform as rows {0E 0B 0D 09} circulant over the same field.
REQ-024 SHALL build all multiplies from xtime:
  - xtime(b) = (b<<1) XOR (0x1B if b[MSB] else 0x00), truncated to 8 bits;
  - no lookup tables.
REQ-025 SHALL be fully combinational within one column per group cycle, with no multicycle paths.
REQ-026 SHALL stop elaboration with an error for any COLS_PER_CYCLE other than 1, 2 or 4.

Reset
REQ-027 SHALL, when rst_n is low at a rising clk edge in any state:
  - enter IDLE;
  - clear the working register, mode register and group counter to 0;
  - drive out_valid=0, busy=0, in_ready=1 on the following cycle.
REQ-028 SHALL discard any block in BUSY or DONE on reset and produce no out_valid for it.
REQ-029 SHALL accept a new block on the first edge after rst_n returns high if in_valid is high.

Verification
REQ-030 SHALL pass forward vectors for each COLS_PER_CYCLE:
  - in_mode=0, columns db135345, f20a225c, 01010101, c6c6c6c6 -> out_data columns 8e4da1bc, 9fdc589d, 01010101, c6c6c6c6;
  - out_valid at exactly 4/COLS_PER_CYCLE cycles after capture.
REQ-031 SHALL pass inverse vectors for each COLS_PER_CYCLE:
  - in_mode=1, columns 8e4da1bc, 9fdc589d, d5d5d7d6, 4d7ebdf8 -> columns db135345, f20a225c, d4d4d4d5, 2d26314c;
  - every block SHALL also round-trip through mode 0 then mode 1 back to the original input, for 1000 random blocks.
REQ-032 SHALL pass backpressure:
  - hold out_ready=0 for 10 cycles in DONE -> out_data/out_valid unchanged, in_ready=0;
  - raise out_ready -> IDLE on the next cycle.
REQ-033 SHALL pass input protection: toggle in_mode and in_data during BUSY with in_valid=1 -> result equals the captured block's result.
REQ-034 SHALL pass reset mid-operation:
  - assert rst_n=0 for one cycle during BUSY at g=1 (COLS_PER_CYCLE=1) -> out_valid never rises for that block, in_ready=1 after reset;
  - the next block completes correctly.
REQ-035 SHALL pass back-to-back: in_valid and out_ready held high for 20 blocks -> one result per 4/COLS_PER_CYCLE+2 cycles, in order, with no drops or duplicates.
